led_seq_ctrl: RTL
=================

Name: led_seq_ctrl

Overview:
Programmable LED blink sequencer driven from the 100 MHz board clock. Holds a small table of (LED pattern, duration) slots and plays them in order, one slot per programmed number of prescaled ticks. It optionally loops back to slot 0 at the end of the table. It sits above the clock-divider tick path and is the block that schedules what the LEDs show and for how long.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz
TICK_HZ, 1_000, duration tick rate; DIV = CLK_HZ/TICK_HZ cycles per tick; DIV >= 2 required
DEPTH, 8, number of pattern slots; power of two
LED_W, 4, LED output width
DUR_W, 16, duration field width, in ticks
AW, $clog2(DEPTH), slot address width (derived)

Ports:
i_clk_100MHz  in  1  system clock; all logic on rising edge
i_clr_n  in  1  asynchronous active-low reset
i_wr_en  in  1  slot write strobe; one write per cycle
i_wr_addr  in  AW  slot index to write
i_wr_pattern  in  LED_W  LED pattern for the slot
i_wr_dur  in  DUR_W  slot duration in ticks
i_last_idx  in  AW  index of last slot played; sampled on accepted start
i_loop  in  1  1 = wrap to slot 0 after last; sampled on accepted start
i_start  in  1  start pulse; accepted only in IDLE
i_stop  in  1  stop pulse
o_leds  out  LED_W  current pattern (registered)
o_busy  out  1  high in RUN
o_step  out  AW  index of slot currently shown
o_tick  out  1  one-cycle tick strobe, RUN only
o_done  out  1  one-cycle pulse when a non-loop sequence completes

Behaviour:
- Reset (i_clr_n low, asynchronous): FSM = IDLE; o_leds, o_busy, o_step, o_tick and o_done all 0; prescaler and remaining-duration counter 0. Slot table contents are not reset; the table is undefined until written.
- Slot table: DEPTH x (LED_W+DUR_W) registers, written on i_wr_en in any state. A write becomes visible on the following cycle. A write to the active slot does not change the current o_leds or remaining count; it applies the next time that slot is loaded.
- FSM states: IDLE and RUN.
- IDLE -> RUN on i_start=1 and i_stop=0:
  - Latch i_last_idx and i_loop.
  - Load slot 0: o_leds = pattern[0], remaining = max(dur[0],1).
  - Clear the prescaler; o_step = 0; o_busy = 1.
  - All of these are visible on the cycle after start (latency 1).
- Start and a write to slot 0 in the same cycle: the start loads the pre-write contents.
- Prescaler (RUN only): counts 0..DIV-1 and wraps. o_tick = 1 for one cycle when the count equals DIV-1.
- On each tick:
  - If remaining > 1: decrement remaining.
  - Else if o_step != last_idx: o_step+1, load that slot; a duration of 0 is treated as 1.
  - Else if loop = 1: o_step = 0, reload slot 0.
  - Else: go to IDLE; o_leds = 0, o_busy = 0, o_step = 0; o_done = 1 for exactly one cycle.
- Each slot is shown for exactly max(dur,1)*DIV cycles; slot changes are contiguous, with no gap cycles.
- i_stop in RUN: IDLE on the next cycle; o_leds = 0, o_busy = 0, o_step = 0, prescaler cleared; o_done is not asserted. Stop has priority over a tick in the same cycle.
- i_stop in IDLE: no effect. i_start in RUN: ignored, with no restart and no relatch.
- i_start and i_stop in the same cycle in IDLE: stop wins and the FSM stays in IDLE.
- last_idx = 0: slot 0 only; with loop = 1 the pattern is held steady until stop.
- Asynchronous reset mid-RUN: outputs go to 0 immediately. No o_done is produced after reset is released.
- Duration arithmetic: unsigned, DUR_W bits; the maximum slot length is (2^DUR_W-1)*DIV cycles.

Test Plan:
(Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), DEPTH=4, LED_W=4, DUR_W=8.)
1. Hold i_clr_n low for 3 cycles, then release -> o_leds=0, o_busy=0, o_step=0, o_tick=0, o_done=0; no o_tick observed over the next 50 cycles.
2. Write slot0=(0001,dur 2) and slot1=(0010,dur 3); set last_idx=1, loop=0; pulse start at cycle S -> o_leds=0001 during S+1..S+20, 0010 during S+21..S+50. At S+51: o_leds=0, o_busy=0, and o_done high for that single cycle.
3. Same table with loop=1 -> o_leds returns to 0001 at S+51 and o_step=0. Pulse stop at S+75 -> at S+76 o_leds=0 and o_busy=0; o_done never asserts.
4. Slot0=(1111,dur 0), last_idx=0, loop=0 -> o_leds=1111 for exactly 10 cycles, then o_done pulses once.
5. Mid-RUN, drive i_clr_n low asynchronously (between clock edges) -> o_leds and o_busy go to 0 before the next edge. After release, no o_tick or o_done occurs until a new start.
6. Start+stop in the same IDLE cycle -> o_busy stays 0. During RUN, pulse start and write slot1=(1000,dur 1) -> no restart; the new slot1 value is shown only when slot1 is next loaded.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: programmable LED blink sequencer.
//
// Holds a DEPTH-entry table of (LED pattern, duration) slots. On start it plays
// the slots 0..last_idx in order. Each slot is held for max(dur,1) prescaled
// ticks, and one tick is DIV = CLK_HZ/TICK_HZ clock cycles. At the end of the
// table it either wraps back to slot 0 (loop) or returns to IDLE and pulses
// o_done.
//
// Handshake: i_start and i_stop are single-cycle pulses, sampled on the rising
// edge. A start is accepted only in IDLE when i_stop is low. A stop moves RUN
// to IDLE on the next cycle and has priority over a tick in the same cycle.
// Table writes are accepted in any cycle in which i_wr_en is high.
//
// Ports:
//   i_clk_100MHz  system clock
//   i_clr_n       asynchronous active-low reset
//   i_wr_en/i_wr_addr/i_wr_pattern/i_wr_dur  slot table write port
//   i_last_idx, i_loop  sequence shape, latched on an accepted start
//   i_start, i_stop     control pulses
//   o_leds        registered LED pattern (0 when idle)
//   o_busy        high in RUN (this is the FSM state)
//   o_step        index of the slot currently shown
//   o_tick        one-cycle tick strobe, RUN only
//   o_done        one-cycle pulse when a non-looping sequence completes
module led_seq_ctrl #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1_000,
    parameter int DEPTH   = 8,
    parameter int LED_W   = 4,
    parameter int DUR_W   = 16,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic             i_clk_100MHz,
    input  logic             i_clr_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [LED_W-1:0] i_wr_pattern,
    input  logic [DUR_W-1:0] i_wr_dur,
    input  logic [AW-1:0]    i_last_idx,
    input  logic             i_loop,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [LED_W-1:0] o_leds,
    output logic             o_busy,
    output logic [AW-1:0]    o_step,
    output logic             o_tick,
    output logic             o_done
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
    localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [LED_W-1:0] leds_q, leds_d;
    logic [AW-1:0]    step_q, step_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [AW-1:0]    last_q, last_d;
    logic             loop_q, loop_d;
    logic             done_q, done_d;

    logic [LED_W-1:0] pat_mem [DEPTH];
    logic [DUR_W-1:0] dur_mem [DEPTH];

    logic             tick;
    logic             slot_end;
    logic             seq_end;
    logic [AW-1:0]    step_inc;

    // A zero duration is shown for one tick rather than being skipped.
    function automatic logic [DUR_W-1:0] nz_dur(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_ONE : d;
    endfunction

    // Slot table: deliberately not reset. Reads see the pre-write contents in
    // the cycle of a write, so a start coinciding with a write to slot 0 loads
    // the old entry.
    always_ff @(posedge i_clk_100MHz) begin
        if (i_wr_en) begin
            pat_mem[i_wr_addr] <= i_wr_pattern;
            dur_mem[i_wr_addr] <= i_wr_dur;
        end
    end

    assign tick     = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
    assign slot_end = tick && (rem_q <= DUR_ONE);
    assign seq_end  = slot_end && (step_q == last_q) && !loop_q;
    assign step_inc = step_q + AW'(1);

    // State register
    always_ff @(posedge i_clk_100MHz or negedge i_clr_n) begin
        if (!i_clr_n) begin
            state_q <= ST_IDLE;
            leds_q  <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            presc_q <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            leds_q  <= leds_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            presc_q <= presc_d;
            last_q  <= last_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start && !i_stop) state_d = ST_RUN;
            ST_RUN:  if (i_stop || seq_end)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        leds_d  = leds_q;
        step_d  = step_q;
        rem_d   = rem_q;
        presc_d = presc_q;
        last_d  = last_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (i_start && !i_stop) begin
                    last_d = i_last_idx;
                    loop_d = i_loop;
                    step_d = '0;
                    leds_d = pat_mem[0];
                    rem_d  = nz_dur(dur_mem[0]);
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    leds_d  = '0;
                    step_d  = '0;
                    rem_d   = '0;
                    presc_d = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (rem_q > DUR_ONE) begin
                            rem_d = rem_q - DUR_ONE;
                        end else if (step_q != last_q) begin
                            step_d = step_inc;
                            leds_d = pat_mem[step_inc];
                            rem_d  = nz_dur(dur_mem[step_inc]);
                        end else if (loop_q) begin
                            step_d = '0;
                            leds_d = pat_mem[0];
                            rem_d  = nz_dur(dur_mem[0]);
                        end else begin
                            leds_d = '0;
                            step_d = '0;
                            rem_d  = '0;
                            done_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign o_leds = leds_q;
    assign o_busy = (state_q == ST_RUN);
    assign o_step = step_q;
    assign o_tick = tick;
    assign o_done = done_q;

endmodule
